// File: rtl/add16_acc_pkg.sv
// Shared types and widths for the add16 result accumulator.
// Min/max helpers are used only when ADD16_ACC_MINMAX_EN is defined.
package add16_acc_pkg;

    localparam int ACC_W       = 32;
    localparam int SUM_W       = 16;
    localparam int LATENCY_DEF = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic logic [SUM_W-1:0] sum_min(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [SUM_W-1:0] sum_max(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/add16_valid_delay.sv
// LATENCY-deep shift register that realigns the operand-valid strobe
// with the adder output it describes.
module add16_valid_delay #(
    parameter int LATENCY = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [LATENCY-1:0] r_sh;

    generate
        if (LATENCY == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sh <= '0;
                else        r_sh <= i_d;
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sh <= '0;
                else        r_sh <= {r_sh[LATENCY-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sh[LATENCY-1];

endmodule

// File: rtl/add16_result_acc.sv
// Accumulates WINDOW valid adder sums into a held valid/ready result.
// Define ADD16_ACC_MINMAX_EN to add per-window res_min/res_max outputs.
module add16_result_acc
    import add16_acc_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEF,
    parameter int WINDOW     = 16,
    parameter int CONTINUOUS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             start,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
`ifdef ADD16_ACC_MINMAX_EN
    output logic [SUM_W-1:0] res_min,
    output logic [SUM_W-1:0] res_max,
`endif
    output logic             overrun,
    input  logic             clear_overrun
);

    localparam logic [15:0] CNT_LAST = 16'(WINDOW - 1);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [15:0]      r_cnt;
    logic             r_res_valid;
    logic [ACC_W-1:0] r_res_sum;
    logic             r_overrun;

    logic             w_s_valid;
    logic             w_sample;
    logic             w_done;
    logic             w_load;
    logic [ACC_W-1:0] w_total;

    add16_valid_delay #(.LATENCY(LATENCY)) u_vdly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (op_valid),
        .o_q   (w_s_valid)
    );

    assign w_sample = (r_state == ACCUM) && w_s_valid;
    assign w_done   = w_sample && (r_cnt == CNT_LAST);
    assign w_total  = r_acc + {{(ACC_W-SUM_W){1'b0}}, sum_in};
    // A held, unconsumed result blocks the load; the new total is dropped.
    assign w_load   = w_done && (!r_res_valid || res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_state <= ACCUM;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
        end else if (w_done) begin
            r_state <= (CONTINUOUS != 0) ? ACCUM : IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_sample) begin
            r_acc <= w_total;
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= w_total;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
            if (w_done && !w_load)  r_overrun <= 1'b1;
            else if (clear_overrun) r_overrun <= 1'b0;
        end
    end

`ifdef ADD16_ACC_MINMAX_EN
    logic [SUM_W-1:0] r_min;
    logic [SUM_W-1:0] r_max;
    logic [SUM_W-1:0] r_res_min;
    logic [SUM_W-1:0] r_res_max;
    logic [SUM_W-1:0] w_cur_min;
    logic [SUM_W-1:0] w_cur_max;

    // The first sample of a window seeds both trackers.
    assign w_cur_min = (r_cnt == 16'd0) ? sum_in : sum_min(r_min, sum_in);
    assign w_cur_max = (r_cnt == 16'd0) ? sum_in : sum_max(r_max, sum_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min     <= '0;
            r_max     <= '0;
            r_res_min <= '0;
            r_res_max <= '0;
        end else begin
            if (w_sample) begin
                r_min <= w_cur_min;
                r_max <= w_cur_max;
            end
            if (w_load) begin
                r_res_min <= w_cur_min;
                r_res_max <= w_cur_max;
            end
        end
    end

    assign res_min = r_res_min;
    assign res_max = r_res_max;
`endif

    assign busy      = (r_state == ACCUM);
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_add16_result_acc.sv
// Randomised and directed bench for add16_result_acc: two instances
// (WINDOW=4 one-shot, WINDOW=2 continuous) share stimulus against a reference model.
module tb_add16_result_acc;

    localparam int LAT = 5;
    localparam int WIN_A = 4;
    localparam int WIN_B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [15:0] sum_in = '0;
    logic        start = 1'b0;
    logic        res_ready = 1'b0;
    logic        clear_overrun = 1'b0;

    logic        busy_a, rv_a, ov_a, busy_b, rv_b, ov_b;
    logic [31:0] rs_a, rs_b;
`ifdef ADD16_ACC_MINMAX_EN
    logic [15:0] mn_a, mx_a, mn_b, mx_b;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    add16_result_acc #(.LATENCY(LAT), .WINDOW(WIN_A), .CONTINUOUS(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .sum_in(sum_in),
        .start(start), .busy(busy_a), .res_valid(rv_a), .res_ready(res_ready),
        .res_sum(rs_a),
`ifdef ADD16_ACC_MINMAX_EN
        .res_min(mn_a), .res_max(mx_a),
`endif
        .overrun(ov_a), .clear_overrun(clear_overrun)
    );

    add16_result_acc #(.LATENCY(LAT), .WINDOW(WIN_B), .CONTINUOUS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .sum_in(sum_in),
        .start(start), .busy(busy_b), .res_valid(rv_b), .res_ready(res_ready),
        .res_sum(rs_b),
`ifdef ADD16_ACC_MINMAX_EN
        .res_min(mn_b), .res_max(mx_b),
`endif
        .overrun(ov_b), .clear_overrun(clear_overrun)
    );

    // Reference model: index 0 is instance A, index 1 is instance B.
    int          win  [2] = '{WIN_A, WIN_B};
    bit          cont [2] = '{1'b0, 1'b1};
    bit          m_in_win [2];
    longint      m_acc [2];
    int          m_cnt [2];
    bit          m_rv  [2];
    longint      m_rs  [2];
    bit          m_ov  [2];
    int          m_wmin [2], m_wmax [2], m_rmin [2], m_rmax [2];
    bit          hist [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in_win[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
            m_rv[k] = 0; m_rs[k] = 0; m_ov[k] = 0;
            m_wmin[k] = 0; m_wmax[k] = 0; m_rmin[k] = 0; m_rmax[k] = 0;
        end
        hist.delete();
    endtask

    task automatic model_step(input bit ov, input bit st, input bit rdy,
                              input bit clr, input int s);
        bit sv;
        sv = (hist.size() >= LAT) ? hist[hist.size()-LAT] : 1'b0;
        hist.push_back(ov);
        if (hist.size() > 16) void'(hist.pop_front());
        for (int k = 0; k < 2; k++) begin
            bit loaded, dropped;
            loaded = 0; dropped = 0;
            if (!m_in_win[k]) begin
                if (st) begin
                    m_in_win[k] = 1; m_acc[k] = 0; m_cnt[k] = 0;
                end
            end else if (sv) begin
                if (m_cnt[k] == 0) begin
                    m_wmin[k] = s; m_wmax[k] = s;
                end else begin
                    if (s < m_wmin[k]) m_wmin[k] = s;
                    if (s > m_wmax[k]) m_wmax[k] = s;
                end
                m_acc[k] += s;
                m_cnt[k]++;
                if (m_cnt[k] == win[k]) begin
                    if (!m_rv[k] || rdy) begin
                        loaded = 1;
                        m_rs[k] = m_acc[k];
                        m_rmin[k] = m_wmin[k];
                        m_rmax[k] = m_wmax[k];
                    end else begin
                        dropped = 1;
                    end
                    m_acc[k] = 0; m_cnt[k] = 0;
                    m_in_win[k] = cont[k];
                end
            end
            if (loaded)             m_rv[k] = 1;
            else if (m_rv[k] && rdy) m_rv[k] = 0;
            if (dropped)  m_ov[k] = 1;
            else if (clr) m_ov[k] = 0;
        end
    endtask

    task automatic compare_all();
        chk("a.busy", 32'(busy_a), 32'(m_in_win[0]));
        chk("a.rv",   32'(rv_a),   32'(m_rv[0]));
        chk("a.sum",  rs_a,        32'(m_rs[0]));
        chk("a.ovr",  32'(ov_a),   32'(m_ov[0]));
        chk("b.busy", 32'(busy_b), 32'(m_in_win[1]));
        chk("b.rv",   32'(rv_b),   32'(m_rv[1]));
        chk("b.sum",  rs_b,        32'(m_rs[1]));
        chk("b.ovr",  32'(ov_b),   32'(m_ov[1]));
`ifdef ADD16_ACC_MINMAX_EN
        chk("a.min", 32'(mn_a), 32'(m_rmin[0]));
        chk("a.max", 32'(mx_a), 32'(m_rmax[0]));
        chk("b.min", 32'(mn_b), 32'(m_rmin[1]));
        chk("b.max", 32'(mx_b), 32'(m_rmax[1]));
`endif
    endtask

    task automatic cyc(input bit ov, input bit st, input bit rdy,
                       input bit clr, input logic [15:0] s);
        op_valid = ov; start = st; res_ready = rdy; clear_overrun = clr; sum_in = s;
        @(posedge clk);
        model_step(ov, st, rdy, clr, int'(s));
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        op_valid = 0; start = 0; res_ready = 0; clear_overrun = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // start + n consecutive op_valid pulses, then idle up to `total` cycles
    task automatic window_run(input int n, input int total, input bit rdy,
                              input logic [15:0] s);
        for (int i = 0; i < total; i++)
            cyc(i < n, i == 0, rdy, 1'b0, s);
    endtask

    initial begin
        longint saved;
        do_reset();

        // Aligned 0x0022 samples
        window_run(4, 9, 1'b1, 16'h0022);
        chk("a.sum88", rs_a, 32'h0000_0088);
        chk("a.busy_fall", 32'(busy_a), 32'd0);
        chk("b.sum44", rs_b, 32'h0000_0044);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(0, 0, 1, 0, 16'h0);

        // Full-scale samples must not truncate
        window_run(4, 9, 1'b1, 16'hFFFF);
        chk("b.sum_ffff", rs_b, 32'h0001_FFFE);
        chk("a.sum_ffff", rs_a, 32'h0003_FFFC);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(0, 0, 1, 0, 16'h0);

        // Stalled consumer: later windows are dropped and flagged
        window_run(8, 14, 1'b0, 16'h0100);
        chk("b.ovr_set", 32'(ov_b), 32'd1);
        chk("b.sum_held", rs_b, 32'h0000_0200);
        window_run(4, 9, 1'b0, 16'h0100);
        chk("a.ovr_set", 32'(ov_a), 32'd1);
        chk("a.sum_held", rs_a, 32'h0000_0400);
        cyc(0, 0, 1, 1, 16'h0);
        chk("a.ovr_clr", 32'(ov_a), 32'd0);
        chk("b.ovr_clr", 32'(ov_b), 32'd0);
        cyc(0, 0, 1, 0, 16'h0);

        // Gapped pulses: sum_in carries the cycle index so arrival time shows in the total
        for (int i = 0; i < 18; i++)
            cyc((i % 4) == 0 && i < 13, i == 0, 1'b1, 1'b0, 16'(i));
        chk("a.sum_gap", rs_a, 32'h0000_002C);
        saved = m_rs[0];
        for (int i = 0; i < 12; i++)
            cyc((i % 4) == 0, 1'b0, 1'b1, 1'b0, 16'h0FFF);
        chk("a.idle_ignored", rs_a, 32'(saved));

        // Reset after two of four samples, then a clean window
        for (int i = 0; i < 7; i++)
            cyc(i < 4, i == 0, 1'b1, 1'b0, 16'h0001);
        do_reset();
        window_run(4, 9, 1'b1, 16'h0001);
        chk("a.sum_after_rst", rs_a, 32'h0000_0004);
        chk("b.sum_after_rst", rs_b, 32'h0000_0002);

`ifdef ADD16_ACC_MINMAX_EN
        begin
            logic [15:0] mm_tbl [4];
            mm_tbl = '{16'd7, 16'd3, 16'd9, 16'd5};
            for (int i = 0; i < 9; i++)
                cyc(i < 4, i == 0, 1'b1, 1'b0, (i >= 5) ? mm_tbl[i-5] : 16'd0);
            chk("a.mm_min", 32'(mn_a), 32'd3);
            chk("a.mm_max", 32'(mx_a), 32'd9);
            chk("a.mm_sum", rs_a, 32'd24);
        end
`endif

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            cyc(1'($urandom_range(0, 1)), ($urandom % 6) == 0, ($urandom % 3) != 0,
                ($urandom % 16) == 0, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
